// File: rtl/decode_issue_queue_pkg.sv
// Shared decode constants and the register-usage record for the issue queue.
package decode_issue_queue_pkg;

  localparam logic [5:0] OP_SPECIAL  = 6'h00;
  localparam logic [5:0] OP_REGIMM   = 6'h01;
  localparam logic [5:0] OP_J        = 6'h02;
  localparam logic [5:0] OP_JAL      = 6'h03;
  localparam logic [5:0] OP_BEQ      = 6'h04;
  localparam logic [5:0] OP_BNE      = 6'h05;
  localparam logic [5:0] OP_BLEZ     = 6'h06;
  localparam logic [5:0] OP_BGTZ     = 6'h07;
  localparam logic [5:0] OP_ADDI     = 6'h08;
  localparam logic [5:0] OP_ADDIU    = 6'h09;
  localparam logic [5:0] OP_SLTI     = 6'h0A;
  localparam logic [5:0] OP_SLTIU    = 6'h0B;
  localparam logic [5:0] OP_ANDI     = 6'h0C;
  localparam logic [5:0] OP_ORI      = 6'h0D;
  localparam logic [5:0] OP_XORI     = 6'h0E;
  localparam logic [5:0] OP_LUI      = 6'h0F;
  localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
  localparam logic [5:0] OP_LB       = 6'h20;
  localparam logic [5:0] OP_LH       = 6'h21;
  localparam logic [5:0] OP_LW       = 6'h23;
  localparam logic [5:0] OP_LBU      = 6'h24;
  localparam logic [5:0] OP_LHU      = 6'h25;
  localparam logic [5:0] OP_SB       = 6'h28;
  localparam logic [5:0] OP_SH       = 6'h29;
  localparam logic [5:0] OP_SW       = 6'h2B;

  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_SRA     = 6'h03;
  localparam logic [5:0] FN_SLLV    = 6'h04;
  localparam logic [5:0] FN_SRLV    = 6'h06;
  localparam logic [5:0] FN_SRAV    = 6'h07;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MTHI    = 6'h11;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MTLO    = 6'h13;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIV     = 6'h1A;
  localparam logic [5:0] FN_DIVU    = 6'h1B;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_XOR     = 6'h26;
  localparam logic [5:0] FN_NOR     = 6'h27;
  localparam logic [5:0] FN_SLT     = 6'h2A;
  localparam logic [5:0] FN_SLTU    = 6'h2B;

  // SPECIAL2 functs
  localparam logic [5:0] FN2_MADD   = 6'h00;
  localparam logic [5:0] FN2_MADDU  = 6'h01;
  localparam logic [5:0] FN2_MSUB   = 6'h04;

  localparam logic [5:0] HILO_IDX = 6'd32;

  typedef struct packed {
    logic       read_rs;
    logic       read_rt;
    logic       read_hilo;
    logic       dst_valid;
    logic [5:0] dst_idx;
    logic       illegal;
  } reg_use_t;

endpackage

// File: rtl/decode_issue_queue_reg_use_decode.sv
// Combinational register-usage decode of one MIPS instruction word.
module reg_use_decode
  import decode_issue_queue_pkg::*;
(
  input  logic [31:0] instr,
  output reg_use_t    ru
);

  logic [5:0] op, fn;
  logic [4:0] rt, rd;

  assign op = instr[31:26];
  assign fn = instr[5:0];
  assign rt = instr[20:16];
  assign rd = instr[15:11];

  always_comb begin
    ru = '0;
    case (op)
      OP_SPECIAL: begin
        case (fn)
          FN_SLL, FN_SRL, FN_SRA: begin
            ru.read_rt = 1'b1; ru.dst_valid = 1'b1; ru.dst_idx = {1'b0, rd};
          end
          FN_SLLV, FN_SRLV, FN_SRAV, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
          FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: begin
            ru.read_rs = 1'b1; ru.read_rt = 1'b1;
            ru.dst_valid = 1'b1; ru.dst_idx = {1'b0, rd};
          end
          FN_JR: ru.read_rs = 1'b1;
          FN_JALR: begin
            ru.read_rs = 1'b1; ru.dst_valid = 1'b1; ru.dst_idx = {1'b0, rd};
          end
          FN_SYSCALL: ;
          FN_MFHI, FN_MFLO: begin
            ru.read_hilo = 1'b1; ru.dst_valid = 1'b1; ru.dst_idx = {1'b0, rd};
          end
          FN_MTHI, FN_MTLO: begin
            ru.read_rs = 1'b1; ru.dst_valid = 1'b1; ru.dst_idx = HILO_IDX;
          end
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
            ru.read_rs = 1'b1; ru.read_rt = 1'b1;
            ru.dst_valid = 1'b1; ru.dst_idx = HILO_IDX;
          end
          default: ru.illegal = 1'b1;
        endcase
      end
      OP_SPECIAL2: begin
        if (fn == FN2_MADD || fn == FN2_MADDU || fn == FN2_MSUB) begin
          ru.read_rs = 1'b1; ru.read_rt = 1'b1;
          ru.dst_valid = 1'b1; ru.dst_idx = HILO_IDX;
        end else begin
          ru.illegal = 1'b1;
        end
      end
      // only bltz (rt=0) and bgez (rt=1) are supported under REGIMM
      OP_REGIMM: begin
        if (rt == 5'd0 || rt == 5'd1) ru.read_rs = 1'b1;
        else                          ru.illegal = 1'b1;
      end
      OP_J: ;
      OP_JAL: begin
        ru.dst_valid = 1'b1; ru.dst_idx = 6'd31;
      end
      OP_BEQ, OP_BNE, OP_SB, OP_SH, OP_SW: begin
        ru.read_rs = 1'b1; ru.read_rt = 1'b1;
      end
      OP_BLEZ, OP_BGTZ: ru.read_rs = 1'b1;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI,
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        ru.read_rs = 1'b1; ru.dst_valid = 1'b1; ru.dst_idx = {1'b0, rt};
      end
      OP_LUI: begin
        ru.dst_valid = 1'b1; ru.dst_idx = {1'b0, rt};
      end
      default: ru.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_issue_queue.sv
// In-order instruction queue with head decode and a GPR/HILO pending-write
// scoreboard that holds issue on RAW/WAW hazards.
module decode_issue_queue
  import decode_issue_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  output logic             issue_valid,
  input  logic             issue_ready,
  output logic [31:0]      issue_instr,
  output logic [PC_W-1:0]  issue_pc,
  output logic             issue_illegal,
  input  logic             wb_valid,
  input  logic [4:0]       wb_reg,
  input  logic             wb_hilo,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic             hazard_stall
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [31:0]      instr_q [DEPTH];
  logic [31:0]      instr_d [DEPTH];
  logic [PC_W-1:0]  pc_q    [DEPTH];
  logic [PC_W-1:0]  pc_d    [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [32:0]      pend_q, pend_d;

  reg_use_t   head;
  logic [31:0] head_instr;
  logic [32:0] clr, eff;
  logic [5:0]  rs_idx, rt_idx;
  logic        nonempty, hazard, enq, deq;

  assign head_instr = instr_q[rd_ptr_q];
  assign rs_idx     = {1'b0, head_instr[25:21]};
  assign rt_idx     = {1'b0, head_instr[20:16]};

  reg_use_decode u_dec (
    .instr (head_instr),
    .ru    (head)
  );

  always_comb begin
    clr = '0;
    if (wb_valid) clr[{1'b0, wb_reg}] = 1'b1;
    if (wb_hilo)  clr[HILO_IDX]       = 1'b1;
  end

  // Writebacks landing this cycle are already considered retired.
  assign eff = pend_q & ~clr;

  always_comb begin
    hazard = 1'b0;
    if (head.read_rs   && rs_idx != 6'd0 && eff[rs_idx]) hazard = 1'b1;
    if (head.read_rt   && rt_idx != 6'd0 && eff[rt_idx]) hazard = 1'b1;
    if (head.read_hilo && eff[HILO_IDX])                 hazard = 1'b1;
    if (head.dst_valid && head.dst_idx != 6'd0 && eff[head.dst_idx]) hazard = 1'b1;
  end

  assign nonempty      = (count_q != '0);
  assign in_ready      = (count_q < CNT_W'(DEPTH));
  assign issue_valid   = nonempty && !hazard && !flush;
  assign hazard_stall  = nonempty && hazard && !flush;
  assign issue_instr   = head_instr;
  assign issue_pc      = pc_q[rd_ptr_q];
  assign issue_illegal = nonempty && head.illegal;
  assign count         = count_q;

  assign enq = in_valid && in_ready && !flush;
  assign deq = issue_valid && issue_ready;

  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    if (enq) begin
      instr_d[wr_ptr_q] = in_instr;
      pc_d[wr_ptr_q]    = in_pc;
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Set is applied after clear so an issuing writer wins over a same-index retire.
  always_comb begin
    pend_d = eff;
    if (deq && head.dst_valid && head.dst_idx != 6'd0) pend_d[head.dst_idx] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      pend_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
    end
  end

  always_ff @(posedge clk) begin
    instr_q <= instr_d;
    pc_q    <= pc_d;
  end

endmodule

// File: tb/tb_decode_issue_queue.sv
// Directed scoreboard bench for decode_issue_queue: stimulus pushes expected
// issues, a negedge monitor pops and compares on every issue handshake.
module tb_decode_issue_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] in_instr, in_pc;
  logic        issue_valid, issue_ready, issue_illegal;
  logic [31:0] issue_instr, issue_pc;
  logic        wb_valid, wb_hilo, flush, hazard_stall;
  logic [4:0]  wb_reg;
  logic [2:0]  count;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        ill;
  } exp_t;
  exp_t expq[$];

  always #5 clk = ~clk;

  decode_issue_queue dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_instr(issue_instr), .issue_pc(issue_pc), .issue_illegal(issue_illegal),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_hilo(wb_hilo),
    .flush(flush), .count(count), .hazard_stall(hazard_stall)
  );

  function automatic logic [31:0] r_op(input int rs, input int rt, input int rd, input int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction

  function automatic logic [31:0] i_op(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Enqueue one instruction; optionally record it as an expected issue.
  task automatic enq(input logic [31:0] pc, input logic [31:0] ins, input bit exp_issue, input bit ill);
    int n = 0;
    exp_t e;
    in_valid = 1'b1; in_pc = pc; in_instr = ins;
    while (!in_ready && n < 50) begin tick(); n++; end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL enq_timeout pc=%0h actual=in_ready_low required=in_ready_high", pc);
    end
    if (exp_issue) begin
      e.pc = pc; e.instr = ins; e.ill = ill;
      expq.push_back(e);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wbg(input int r);
    wb_valid = 1'b1; wb_reg = 5'(r);
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic wbh();
    wb_hilo = 1'b1;
    tick();
    wb_hilo = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset && issue_valid && issue_ready) begin
      checks++;
      if (expq.size() == 0) begin
        failures++;
        $display("FAIL issue_unexpected actual_pc=%0h required=no_issue", issue_pc);
      end else begin
        e = expq.pop_front();
        if (issue_pc !== e.pc || issue_instr !== e.instr || issue_illegal !== e.ill) begin
          failures++;
          $display("FAIL issue_order actual=%0h/%0h/%0b required=%0h/%0h/%0b",
                   issue_pc, issue_instr, issue_illegal, e.pc, e.instr, e.ill);
        end
      end
    end
  end

  initial begin
    int n;
    reset = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    issue_ready = 1'b0; wb_valid = 1'b0; wb_reg = '0; wb_hilo = 1'b0; flush = 1'b0;
    tick(); tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_count", count, 0);
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_hazard", hazard_stall, 0);
    chk("rst_illegal", issue_illegal, 0);
    reset = 1'b1;

    // fill: four accepted, fifth held off by in_ready
    for (int i = 0; i < 4; i++)
      enq(32'h100 + 32'(4*i), i_op(6'h09, 0, i + 1, i), 1'b1, 1'b0);
    in_valid = 1'b1; in_pc = 32'h110; in_instr = i_op(6'h09, 0, 5, 4);
    chk("full_in_ready", in_ready, 0);
    chk("full_count", count, 4);
    chk("full_issue_valid", issue_valid, 1);
    tick();
    in_valid = 1'b0;
    chk("full_hold_count", count, 4);
    issue_ready = 1'b1;
    repeat (4) tick();
    chk("drain_count", count, 0);
    for (int r = 1; r <= 4; r++) wbg(r);

    // lw $8 -> addu $9,$8,$8 RAW, same-cycle writeback release
    enq(32'h200, i_op(6'h23, 0, 8, 0), 1'b1, 1'b0);
    enq(32'h204, r_op(8, 8, 9, 6'h21), 1'b1, 1'b0);
    chk("raw_stall", hazard_stall, 1);
    chk("raw_issue_valid", issue_valid, 0);
    tick();
    chk("raw_stall_hold", hazard_stall, 1);
    wb_valid = 1'b1; wb_reg = 5'd8; #1;
    chk("raw_wb_release", issue_valid, 1);
    chk("raw_wb_hazard", hazard_stall, 0);
    tick();
    wb_valid = 1'b0;
    chk("raw_count", count, 0);
    wbg(9);

    // mult -> mflo (HILO RAW), mult -> mthi (HILO WAW), set beats clear
    enq(32'h300, r_op(1, 2, 0, 6'h18), 1'b1, 1'b0);
    enq(32'h304, r_op(0, 0, 3, 6'h12), 1'b1, 1'b0);
    chk("hilo_raw_stall", hazard_stall, 1);
    tick();
    wb_hilo = 1'b1; #1;
    chk("hilo_raw_release", issue_valid, 1);
    tick();
    wb_hilo = 1'b0;
    enq(32'h308, r_op(1, 2, 0, 6'h18), 1'b1, 1'b0);
    enq(32'h30C, r_op(5, 0, 0, 6'h11), 1'b1, 1'b0);
    chk("hilo_waw_stall", hazard_stall, 1);
    wbh();
    enq(32'h310, r_op(0, 0, 6, 6'h12), 1'b1, 1'b0);
    chk("hilo_set_wins", hazard_stall, 1);
    wbh();
    wbg(3); wbg(6);

    // flush with three queued and concurrent in_valid; lw $8 stays pending
    enq(32'h400, i_op(6'h23, 0, 8, 0), 1'b1, 1'b0);
    tick();
    issue_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      enq(32'h404 + 32'(4*i), i_op(6'h09, 0, 11, 7), 1'b0, 1'b0);
    chk("flush_pre_count", count, 3);
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h4F0; in_instr = i_op(6'h09, 0, 11, 1); #1;
    chk("flush_issue_valid", issue_valid, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_issue_valid_after", issue_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    issue_ready = 1'b1;
    enq(32'h420, r_op(8, 8, 10, 6'h21), 1'b1, 1'b0);
    chk("flush_pend_kept", hazard_stall, 1);
    wbg(8);
    wbg(10);

    // $0 writes never hazard; unknown opcode issues as illegal
    enq(32'h500, i_op(6'h09, 0, 0, 1), 1'b1, 1'b0);
    enq(32'h504, r_op(0, 0, 4, 6'h21), 1'b1, 1'b0);
    chk("zero_no_stall", hazard_stall, 0);
    chk("zero_issue_valid", issue_valid, 1);
    tick();
    enq(32'h508, 32'hFC00_0000, 1'b1, 1'b1);
    chk("illegal_flag", issue_illegal, 1);
    tick();
    chk("illegal_count", count, 0);
    wbg(4);

    // reset mid-stall clears queue and scoreboard
    enq(32'h600, i_op(6'h23, 0, 8, 0), 1'b1, 1'b0);
    tick();
    enq(32'h604, r_op(8, 8, 9, 6'h21), 1'b0, 1'b0);
    enq(32'h608, r_op(8, 8, 9, 6'h21), 1'b0, 1'b0);
    chk("prerst_count", count, 2);
    chk("prerst_stall", hazard_stall, 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("midrst_count", count, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_issue_valid", issue_valid, 0);
    chk("midrst_hazard", hazard_stall, 0);
    enq(32'h610, r_op(8, 8, 9, 6'h21), 1'b1, 1'b0);
    chk("midrst_pend_clear", hazard_stall, 0);
    chk("midrst_pend_issue", issue_valid, 1);
    tick();
    wbg(8);
    enq(32'h614, r_op(8, 0, 12, 6'h21), 1'b1, 1'b0);
    tick();

    n = 0;
    while (expq.size() != 0 && n < 20) begin tick(); n++; end
    chk("drain_expected", 32'(expq.size()), 0);
    chk("final_count", count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
